// File: rtl/rcc_div_ratio_ctrl.sv
// ---------------------------------------------------------------------------
// rcc_div_ratio_ctrl
//  Ratio-update initiator for one dynamic clock divider. A ratio change
//  request from the CSR side is applied to the divider in a glitch-safe
//  order. The divider is first gated with ratio 0 for SETTLE_CYC cycles. The
//  new ratio is then held for SETTLE_CYC cycles. Finally the block waits for
//  the divider's activity flag to confirm that it is running again.
//
// Ports
//  clk        control clock
//  rst        synchronous, active-high reset
//  req_valid  ratio change request
//  req_ratio  requested ratio (0 = gate the divider)
//  req_ready  request accepted when req_valid & req_ready (IDLE only)
//  ratio_o    registered ratio driven to the divider
//  div_en_i   divider activity flag, asynchronous to clk
//  busy       update in progress
//  cur_ratio  last committed ratio
//  done       1-cycle pulse, update finished successfully
//  err        1-cycle pulse, confirmation timed out
// ---------------------------------------------------------------------------
module rcc_div_ratio_ctrl #(
   parameter int RATIO_WID   = 8,
   parameter int RESET_RATIO = 1,
   parameter int SETTLE_CYC  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic [RATIO_WID-1:0] req_ratio,
   output logic                 req_ready,
   output logic [RATIO_WID-1:0] ratio_o,
   input  logic                 div_en_i,
   output logic                 busy,
   output logic [RATIO_WID-1:0] cur_ratio,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GATE,
      S_LOAD,
      S_CONFIRM
   } state_e;

   // One down-counter serves both the settle phases and the confirm timeout.
   localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT) ? SETTLE_CYC : TIMEOUT;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0]     SETTLE_LD  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0]     TIMEOUT_LD = CNT_W'(TIMEOUT - 1);
   localparam logic [RATIO_WID-1:0] RST_RATIO  = RATIO_WID'(RESET_RATIO);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [RATIO_WID-1:0]   nr_q, nr_d;
   logic [RATIO_WID-1:0]   ratio_q, ratio_d;
   logic [RATIO_WID-1:0]   cur_q, cur_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;

   logic den_s;
   logic accept;
   logic fin_ok;
   logic fin_err;

   // Plain synchronizer chain; the flag is only looked at in CONFIRM.
   assign sync_d = {sync_q[SYNC_STAGES-2:0], div_en_i};
   assign den_s  = sync_q[SYNC_STAGES-1];

   assign accept = req_valid && (state_q == S_IDLE);

   // -------------------------------------------------------------------------
   // State register (and all other flops)
   // -------------------------------------------------------------------------
   // NOTE: reset is sampled on the clock edge only, so rst mid-update simply
   // wins over the computed next state on that edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: non-blocking assignments keep every flop reading pre-edge values.
         state_q <= S_IDLE;
         cnt_q   <= '0;
         nr_q    <= '0;
         ratio_q <= RST_RATIO;
         cur_q   <= RST_RATIO;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nr_q    <= nr_d;
         ratio_q <= ratio_d;
         cur_q   <= cur_d;
         done_q  <= done_d;
         err_q   <= err_d;
         sync_q  <= sync_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      nr_d    = nr_q;
      fin_ok  = 1'b0;
      fin_err = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               nr_d = req_ratio;
               // Re-requesting the committed ratio completes without gating.
               if (req_ratio == cur_q) begin
                  fin_ok = 1'b1;
               end else begin
                  state_d = S_GATE;
                  cnt_d   = SETTLE_LD;
               end
            end
         end
         S_GATE: begin
            if (cnt_q == '0) begin
               if (nr_q == '0) begin
                  // Gating was the whole request: the divider stays stopped.
                  state_d = S_IDLE;
                  fin_ok  = 1'b1;
               end else begin
                  state_d = S_LOAD;
                  cnt_d   = SETTLE_LD;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_LOAD: begin
            if (cnt_q == '0) begin
               state_d = S_CONFIRM;
               cnt_d   = TIMEOUT_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_CONFIRM: begin
            if (den_s) begin
               state_d = S_IDLE;
               fin_ok  = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = S_IDLE;
               fin_err = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Output logic
   // -------------------------------------------------------------------------
   always_comb begin
      // Ratio follows the phase being entered; IDLE holds whatever was last
      // driven (0 after a gate-only request, nr after confirm or timeout).
      unique case (state_d)
         S_GATE:            ratio_d = '0;
         S_LOAD, S_CONFIRM: ratio_d = nr_d;
         default:           ratio_d = ratio_q;
      endcase
      // A timed-out update is still committed: the divider holds nr.
      cur_d  = (fin_ok || fin_err) ? nr_d : cur_q;
      done_d = fin_ok;
      err_d  = fin_err;
   end

   assign req_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign ratio_o   = ratio_q;
   assign cur_ratio = cur_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_rcc_div_ratio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rcc_div_ratio_ctrl
//  Directed bench for rcc_div_ratio_ctrl with default parameters
//  (RATIO_WID=8, RESET_RATIO=1, SETTLE_CYC=4, SYNC_STAGES=2, TIMEOUT=64).
//  Inputs change and outputs are sampled 1 ns after each rising edge. Cycle 0
//  of a request is the cycle in which req_valid is first presented.
// ---------------------------------------------------------------------------
module tb_rcc_div_ratio_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic [7:0] req_ratio;
   logic       req_ready;
   logic [7:0] ratio_o;
   logic       div_en_i;
   logic       busy;
   logic [7:0] cur_ratio;
   logic       done;
   logic       err;

   int vectors     = 0;
   int miscompares = 0;

   rcc_div_ratio_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ratio (req_ratio),
      .req_ready (req_ready),
      .ratio_o   (ratio_o),
      .div_en_i  (div_en_i),
      .busy      (busy),
      .cur_ratio (cur_ratio),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int done_cyc;

   initial begin
      // ---- 1: reset held for three edges ----
      rst       = 1'b1;
      req_valid = 1'b0;
      req_ratio = 8'd0;
      div_en_i  = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      check("rst ratio_o",   ratio_o,   8'd1);
      check("rst cur_ratio", cur_ratio, 8'd1);
      check("rst req_ready", req_ready, 1'b1);
      check("rst busy",      busy,      1'b0);
      check("rst done",      done,      1'b0);
      check("rst err",       err,       1'b0);

      // ---- 2: ratio 1 -> 8, div_en high from cycle 6, extra req in cycle 2 ----
      req_valid = 1'b1;
      req_ratio = 8'd8;
      for (int c = 1; c <= 11; c++) begin
         step();
         req_valid = (c == 2);
         req_ratio = (c == 2) ? 8'h55 : 8'h08;
         div_en_i  = (c >= 6);
         check("t2 ratio_o",   ratio_o,   (c <= 4) ? 0 : 8);
         check("t2 done",      done,      c == 10);
         check("t2 err",       err,       1'b0);
         check("t2 busy",      busy,      c <= 9);
         check("t2 req_ready", req_ready, c >= 10);
         check("t2 cur_ratio", cur_ratio, (c >= 10) ? 8 : 1);
      end

      // ---- 4: re-request the committed ratio 8 ----
      req_valid = 1'b1;
      req_ratio = 8'd8;
      for (int c = 1; c <= 2; c++) begin
         step();
         req_valid = 1'b0;
         check("t4 ratio_o",   ratio_o,   8'd8);
         check("t4 done",      done,      c == 1);
         check("t4 busy",      busy,      1'b0);
         check("t4 cur_ratio", cur_ratio, 8'd8);
      end

      // ---- 3: gate only, ratio 8 -> 0 ----
      req_valid = 1'b1;
      req_ratio = 8'd0;
      for (int c = 1; c <= 6; c++) begin
         step();
         req_valid = 1'b0;
         check("t3 ratio_o",   ratio_o,   8'd0);
         check("t3 done",      done,      c == 5);
         check("t3 err",       err,       1'b0);
         check("t3 busy",      busy,      c <= 4);
         check("t3 cur_ratio", cur_ratio, (c >= 5) ? 0 : 8);
      end

      // ---- 5: ratio 0 -> 3 with the divider never reporting activity ----
      req_valid = 1'b1;
      req_ratio = 8'd3;
      div_en_i  = 1'b0;
      for (int c = 1; c <= 74; c++) begin
         step();
         req_valid = 1'b0;
         check("t5 ratio_o",   ratio_o,   (c <= 4) ? 0 : 3);
         check("t5 done",      done,      1'b0);
         check("t5 err",       err,       c == 73);
         check("t5 busy",      busy,      c <= 72);
         check("t5 cur_ratio", cur_ratio, (c >= 73) ? 3 : 0);
      end

      // ---- 6: reset during LOAD of ratio 5, then a fresh request ----
      req_valid = 1'b1;
      req_ratio = 8'd5;
      for (int c = 1; c <= 6; c++) begin
         step();
         req_valid = 1'b0;
         check("t6 ratio_o", ratio_o, (c <= 4) ? 0 : 5);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6 rst ratio_o",   ratio_o,   8'd1);
      check("t6 rst busy",      busy,      1'b0);
      check("t6 rst req_ready", req_ready, 1'b1);
      check("t6 rst done",      done,      1'b0);
      check("t6 rst err",       err,       1'b0);
      check("t6 rst cur_ratio", cur_ratio, 8'd1);

      req_valid = 1'b1;
      req_ratio = 8'd2;
      div_en_i  = 1'b1;
      step();
      req_valid = 1'b0;
      check("t6 new busy",    busy,    1'b1);
      check("t6 new ratio_o", ratio_o, 8'd0);
      done_cyc = 0;
      for (int c = 2; c <= 20; c++) begin
         step();
         check("t6 new err", err, 1'b0);
         if (done && done_cyc == 0) done_cyc = c;
      end
      // Confirm is seen on its first cycle (9), so done lands in cycle 10.
      check("t6 done cycle",    done_cyc,  10);
      check("t6 new cur_ratio", cur_ratio, 8'd2);
      check("t6 new ratio_o",   ratio_o,   8'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
